// File: rtl/uart_word_tx.sv
// Buffered 16-bit word UART transmitter: each word leaves as a frame 0xA5, hi, lo, 8N1, LSB first.
// Define UART_TX_CHKSUM_EN to append a fourth byte, 0xA5 ^ hi ^ lo, to every frame.
module uart_word_tx #(
    parameter int CLK_FRE    = 50000000,
    parameter int UART_BPS   = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [15:0]                   word_data,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic                          uart_s,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int BPS_CNT = CLK_FRE / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [7:0] HEADER = 8'hA5;
`ifdef UART_TX_CHKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [15:0]       frame_q, frame_d;
    logic              uart_s_q, uart_s_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [15:0]       mem_d [FIFO_DEPTH];

    logic              full, empty, push, pop, baud_done;
    logic [7:0]        tx_byte;

    function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = HEADER;
            2'd1:    b = w[15:8];
            2'd2:    b = w[7:0];
`ifdef UART_TX_CHKSUM_EN
            default: b = HEADER ^ w[15:8] ^ w[7:0];
`else
            default: b = 8'hFF;
`endif
        endcase
        return b;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = word_valid && !full;
    assign word_ready = !full;
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign tx_busy    = (state_q != S_IDLE) || !empty;
    assign uart_s     = uart_s_q;
    assign baud_done  = (cnt_q == CNT_LAST);

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = word_data;
        end
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        pop        = 1'b0;
        uart_s_d   = 1'b1;
        tx_byte    = 8'hFF;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    frame_d    = mem_q[rd_ptr_q[AW-1:0]];
                    byte_idx_d = 2'd0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_START;
                    end else if (!empty) begin
                        // Chain straight into the next frame with no idle bit.
                        pop        = 1'b1;
                        frame_d    = mem_q[rd_ptr_q[AW-1:0]];
                        byte_idx_d = 2'd0;
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The line is registered from the next-state view so it changes on the entry edge.
        tx_byte = byte_sel(frame_d, byte_idx_d);
        case (state_d)
            S_START: uart_s_d = 1'b0;
            S_DATA:  uart_s_d = tx_byte[bit_idx_d];
            default: uart_s_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            uart_s_q   <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            uart_s_q   <= uart_s_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        frame_q <= frame_d;
        mem_q   <= mem_d;
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomized self-checking bench for uart_word_tx at BPS_CNT=10; a line decoder compares
// received bytes against a byte queue built from every accepted word.
module tb_uart_word_tx;

    localparam int BIT = 10;
`ifdef UART_TX_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int FRAME = NB * 10 * BIT;

    logic        clk;
    logic        rst_n;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        uart_s;
    logic        tx_busy;
    logic [3:0]  fifo_cnt;

    int          n_err;
    int          n_chk;
    logic [7:0]  exp_q [$];

    uart_word_tx #(
        .CLK_FRE   (1000),
        .UART_BPS  (100),
        .FIFO_DEPTH(8)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst_n),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .uart_s    (uart_s),
        .tx_busy   (tx_busy),
        .fifo_cnt  (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the bytes a word must produce on the line.
    task automatic add_word(input logic [15:0] w);
        exp_q.push_back(8'hA5);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
`ifdef UART_TX_CHKSUM_EN
        exp_q.push_back(8'hA5 ^ w[15:8] ^ w[7:0]);
`endif
    endtask

    task automatic push_word(input logic [15:0] w);
        int t;
        word_data  = w;
        word_valid = 1'b1;
        t = 0;
        while (!word_ready && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 4000) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        add_word(w);
        #1;
        word_valid = 1'b0;
    endtask

    task automatic wait_busy_low(input int max, output int n);
        n = 0;
        while (tx_busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Line decoder: every bit must hold one level for exactly BIT samples.
    initial begin : monitor
        logic       mon_busy;
        logic       mon_ok;
        int         mon_o;
        logic [9:0] mon_bits;
        logic [7:0] eb;
        mon_busy = 1'b0;
        mon_ok   = 1'b1;
        mon_o    = 0;
        mon_bits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy = 1'b0;
            end else begin
                if (!mon_busy && uart_s === 1'b0) begin
                    mon_busy = 1'b1;
                    mon_o    = 0;
                    mon_ok   = 1'b1;
                end
                if (mon_busy) begin
                    if (mon_o % BIT == 0) mon_bits[mon_o / BIT] = uart_s;
                    else if (uart_s !== mon_bits[mon_o / BIT]) mon_ok = 1'b0;
                    if (mon_o == 10 * BIT - 1) begin
                        mon_busy = 1'b0;
                        check("frame_bits", {29'd0, mon_ok, mon_bits[0], mon_bits[9]}, 32'd5);
                        if (exp_q.size() == 0) begin
                            check("unexp_byte", {24'd0, mon_bits[8:1]}, 32'h100);
                        end else begin
                            eb = exp_q.pop_front();
                            check("rx_byte", {24'd0, mon_bits[8:1]}, {24'd0, eb});
                        end
                    end else begin
                        mon_o++;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          bad;
        int          n;
        logic [15:0] w9 [9];
        n_err      = 0;
        n_chk      = 0;
        rst_n      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_s", 32'(uart_s), 32'd1);
        check("rst_ready", 32'(word_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        rst_n = 1'b1;

        bad = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (uart_s !== 1'b1 || word_ready !== 1'b1 || tx_busy !== 1'b0 || fifo_cnt !== 4'd0) bad++;
        end
        check("idle_1000", 32'(bad), 32'd0);

        // Single word: latency and frame length.
        push_word(16'h1234);
        check("busy_after_push", 32'(tx_busy), 32'd1);
        check("no_early_fall", 32'(uart_s), 32'd1);
        check("cnt_after_push", 32'(fifo_cnt), 32'd1);
        @(posedge clk);
        #1;
        check("fall_after_pop", 32'(uart_s), 32'd0);
        check("cnt_after_pop", 32'(fifo_cnt), 32'd0);
        wait_busy_low(FRAME + 50, n);
        check("frame_len", 32'(n), 32'(FRAME));
        check("rx_1234_done", 32'(exp_q.size()), 32'd0);

        // Back-to-back extremes: no idle gap between frames.
        push_word(16'h0000);
        push_word(16'hFFFF);
        wait_busy_low(2 * FRAME + 50, n);
        check("b2b_len", 32'(n), 32'(2 * FRAME));
        check("b2b_done", 32'(exp_q.size()), 32'd0);

        // Nine random words without gaps fill the FIFO.
        for (int i = 0; i < 9; i++) w9[i] = 16'($urandom);
        for (int i = 0; i < 9; i++) push_word(w9[i]);
        check("full_cnt", 32'(fifo_cnt), 32'd8);
        check("full_ready", 32'(word_ready), 32'd0);
        n = 0;
        while (!word_ready && n < FRAME + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_rise_at", 32'(n), 32'(FRAME - 7));
        check("cnt_after_rise", 32'(fifo_cnt), 32'd7);
        wait_busy_low(9 * FRAME + 100, n);
        check("nine_done", 32'(exp_q.size()), 32'd0);

        // Push lands on the pop edge with three words buffered.
        for (int i = 0; i < 4; i++) push_word(16'($urandom));
        repeat (FRAME - 3) @(posedge clk);
        #1;
        check("cnt_pre_pushpop", 32'(fifo_cnt), 32'd3);
        push_word(16'($urandom));
        check("cnt_pushpop", 32'(fifo_cnt), 32'd3);
        wait_busy_low(5 * FRAME + 100, n);
        check("pushpop_done", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the low byte's data bits.
        push_word(16'h1200);
        push_word(16'($urandom));
        push_word(16'($urandom));
        repeat (239) @(posedge clk);
        #1;
        check("pre_rst_low", 32'(uart_s), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_uart_s", 32'(uart_s), 32'd1);
        check("midrst_cnt", 32'(fifo_cnt), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_ready", 32'(word_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_word(16'hBEEF);
        wait_busy_low(FRAME + 50, n);
        check("beef_len", 32'(n), 32'(FRAME + 1));
        check("beef_done", 32'(exp_q.size()), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("final_idle_line", 32'(uart_s), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
